tdm_demux3: RTL
===============

Name: tdm_demux3

Overview:
- Receive end of the team's 3-channel time-division link.
- The transmit side uses a 3:1 mux to serialise channels D0/D1/D2 into one bit stream, with a frame marker on the first bit.
- This block locks onto the marker, deserialises the three slots and presents them as parallel words with a one-cycle frame strobe.
- Sits between the serial line interface and the channel consumers.

Parameters:
- WIDTH, 4, bits per slot (>=2). Slots are sent MSB first.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- bit_en  input  1  bit strobe; ser_in and sync_in are sampled only on edges where bit_en=1
- ser_in  input  1  serial data bit
- sync_in  input  1  frame marker, high on bit 0 (MSB) of slot 0
- d0_out  output  WIDTH  last complete slot-0 word
- d1_out  output  WIDTH  last complete slot-1 word
- d2_out  output  WIDTH  last complete slot-2 word
- frame_valid  output  1  one-cycle pulse: d*_out just updated
- sync_err  output  1  one-cycle pulse: framing violation
- locked  output  1  high while frame alignment is held

Behaviour:
- Reset:
  - all outputs 0; state HUNT; bit and slot counters 0; shift and staging registers cleared.
  - rst mid-frame abandons the partial frame; no frame_valid is produced for it.
- bit_en=0: no state change. sync_in and ser_in are ignored. Pulses still deassert after one cycle.
- HUNT:
  - Waits for bit_en & sync_in. That bit is slot0 bit0: shift it in, bit_cnt=1, slot=0, go to RECV.
  - Bits without sync are discarded.
- RECV:
  - Each strobed bit shifts into the shift register, MSB first.
  - On the last bit of a slot (bit_cnt=WIDTH-1), the assembled word goes into that slot's staging register, bit_cnt=0 and slot increments.
  - Last bit of slot 2: on that same edge, d0_out/d1_out/d2_out load together (slot2 direct from the shift path). frame_valid=1 for the following cycle; locked=1; slot wraps to 0. The next strobed bit is expected to be slot0 bit0.
- Expected frame start (slot0 bit0 after a completed frame):
  - sync_in=1: continue in RECV.
  - sync_in=0: sync_err pulse, locked=0, bit discarded, go to HUNT.
- Early sync (sync_in=1 on any other strobed bit in RECV):
  - sync_err pulse; locked=0; partial frame discarded.
  - That bit is treated as slot0 bit0 (immediate resync); stay in RECV.
- First frame after HUNT: locked rises with its frame_valid.
- Outputs hold their value between frames and across errors.
- Latency: d*_out change on the edge sampling the final bit; frame_valid is high in the cycle after that edge.
- No back-pressure. Consumers must take the data while frame_valid is high or before the next frame completes.

Optional Feature:
- Macro: TDM_PARITY_EN.
- Defined:
  - Each slot is WIDTH+1 bits; the extra trailing bit is even parity over the slot's WIDTH data bits.
  - Extra output port parity_err (1 bit), a one-cycle pulse at frame completion if any slot's parity failed.
  - On a failing frame, d*_out are not updated and frame_valid stays 0.
  - locked is unaffected by parity failures.
- Undefined: slots are WIDTH bits, no parity bit, no parity_err port.

Test Plan:
- WIDTH=4, bit_en tied 1: reset, then send slots 0xA,0x5,0xC with sync on the first bit -> after the 12th bit edge d0=A, d1=5, d2=C, frame_valid high exactly one cycle, locked=1, sync_err=0.
- bit_en every other cycle, back-to-back frames 3,7,F then 1,2,4 -> two frame_valid pulses 24 clk apart; outputs 3,7,F then 1,2,4; locked stays 1.
- After a good frame (3,7,F), next frame sent without sync -> sync_err pulse on that first bit, locked=0, outputs hold 3,7,F. No frame_valid until a synced frame 9,9,9 arrives, which then captures correctly.
- sync_in asserted on slot1 bit2 -> sync_err pulse, locked=0. Resync treats that bit as slot0 MSB; a complete frame 6,B,1 starting there -> d*=6,B,1 and frame_valid.
- rst pulsed after 6 bits of a frame -> all outputs 0, no frame_valid. The next synced frame 2,4,8 is captured normally.
- TDM_PARITY_EN defined: frame 0xA,0x5,0xC with bad parity on slot 1 -> parity_err pulse, frame_valid 0, outputs unchanged, locked=1. The same frame with correct parity then updates outputs.

Source files
------------

// File: rtl/tdm_demux3.sv
// Receive side of the 3-slot TDM link: locks on the frame marker, deserialises slots 0..2, strobes frames.
// Optional TDM_PARITY_EN: each slot carries a trailing even-parity bit, and parity_err flags bad frames.
module tdm_demux3 #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             bit_en,
  input  logic             ser_in,
  input  logic             sync_in,
  output logic [WIDTH-1:0] d0_out,
  output logic [WIDTH-1:0] d1_out,
  output logic [WIDTH-1:0] d2_out,
  output logic             frame_valid,
  output logic             sync_err,
`ifdef TDM_PARITY_EN
  output logic             parity_err,
`endif
  output logic             locked
);

`ifdef TDM_PARITY_EN
  localparam int SHW = WIDTH;      // the full word must be kept until the parity bit arrives
`else
  localparam int SHW = WIDTH - 1;
`endif
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic {HUNT, RECV} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [1:0]       slot_q, slot_d;
  logic [SHW-1:0]   sh_q, sh_d;
  logic [WIDTH-1:0] s0_q, s0_d, s1_q, s1_d;
  logic [WIDTH-1:0] d0_q, d0_d, d1_q, d1_d, d2_q, d2_d;
  logic             fv_q, fv_d, se_q, se_d, lk_q, lk_d;
  logic [WIDTH-1:0] word;
`ifdef TDM_PARITY_EN
  logic             perr_q, perr_d, pe_q, pe_d, pall;
`endif

  assign word = {sh_q[WIDTH-2:0], ser_in};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    slot_d  = slot_q;
    sh_d    = sh_q;
    s0_d    = s0_q;
    s1_d    = s1_q;
    d0_d    = d0_q;
    d1_d    = d1_q;
    d2_d    = d2_q;
    fv_d    = 1'b0;
    se_d    = 1'b0;
    lk_d    = lk_q;
`ifdef TDM_PARITY_EN
    perr_d  = perr_q;
    pe_d    = 1'b0;
    pall    = perr_q | (^{sh_q, ser_in});
`endif
    if (bit_en) begin
      unique case (state_q)
        HUNT: begin
          if (sync_in) begin
            sh_d    = word[SHW-1:0];
            cnt_d   = CW'(1);
            slot_d  = 2'd0;
            state_d = RECV;
`ifdef TDM_PARITY_EN
            perr_d  = 1'b0;
`endif
          end
        end
        default: begin
          // cnt=0/slot=0 in RECV only occurs right after a completed frame
          if (cnt_q == '0 && slot_q == 2'd0) begin
            if (sync_in) begin
              sh_d   = word[SHW-1:0];
              cnt_d  = CW'(1);
`ifdef TDM_PARITY_EN
              perr_d = 1'b0;
`endif
            end else begin
              se_d    = 1'b1;
              lk_d    = 1'b0;
              state_d = HUNT;
            end
          end else if (sync_in) begin
            se_d   = 1'b1;
            lk_d   = 1'b0;
            sh_d   = word[SHW-1:0];
            cnt_d  = CW'(1);
            slot_d = 2'd0;
`ifdef TDM_PARITY_EN
            perr_d = 1'b0;
`endif
          end else begin
`ifdef TDM_PARITY_EN
            if (cnt_q == CW'(WIDTH)) begin
              cnt_d  = '0;
              perr_d = pall;
              unique case (slot_q)
                2'd0:    begin s0_d = sh_q; slot_d = 2'd1; end
                2'd1:    begin s1_d = sh_q; slot_d = 2'd2; end
                default: begin
                  slot_d = 2'd0;
                  lk_d   = 1'b1;
                  if (pall) pe_d = 1'b1;
                  else begin
                    d0_d = s0_q;
                    d1_d = s1_q;
                    d2_d = sh_q;
                    fv_d = 1'b1;
                  end
                end
              endcase
            end else begin
              sh_d  = word;
              cnt_d = cnt_q + CW'(1);
            end
`else
            sh_d = word[SHW-1:0];
            if (cnt_q == CW'(WIDTH - 1)) begin
              cnt_d = '0;
              unique case (slot_q)
                2'd0:    begin s0_d = word; slot_d = 2'd1; end
                2'd1:    begin s1_d = word; slot_d = 2'd2; end
                default: begin
                  d0_d   = s0_q;
                  d1_d   = s1_q;
                  d2_d   = word;
                  fv_d   = 1'b1;
                  lk_d   = 1'b1;
                  slot_d = 2'd0;
                end
              endcase
            end else begin
              cnt_d = cnt_q + CW'(1);
            end
`endif
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= HUNT;
      cnt_q   <= '0;
      slot_q  <= '0;
      sh_q    <= '0;
      s0_q    <= '0;
      s1_q    <= '0;
      d0_q    <= '0;
      d1_q    <= '0;
      d2_q    <= '0;
      fv_q    <= 1'b0;
      se_q    <= 1'b0;
      lk_q    <= 1'b0;
`ifdef TDM_PARITY_EN
      perr_q  <= 1'b0;
      pe_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      slot_q  <= slot_d;
      sh_q    <= sh_d;
      s0_q    <= s0_d;
      s1_q    <= s1_d;
      d0_q    <= d0_d;
      d1_q    <= d1_d;
      d2_q    <= d2_d;
      fv_q    <= fv_d;
      se_q    <= se_d;
      lk_q    <= lk_d;
`ifdef TDM_PARITY_EN
      perr_q  <= perr_d;
      pe_q    <= pe_d;
`endif
    end
  end

  assign d0_out      = d0_q;
  assign d1_out      = d1_q;
  assign d2_out      = d2_q;
  assign frame_valid = fv_q;
  assign sync_err    = se_q;
  assign locked      = lk_q;
`ifdef TDM_PARITY_EN
  assign parity_err  = pe_q;
`endif

endmodule
